// File: rtl/ula_seq_pkg.sv
// ---------------------------------------------------------------------------
// ula_seq_pkg
// Shared types and constants for the ULA instruction sequencer.
//   state_e       : sequencer states (3-bit encoding)
//   OP_W_DEF      : default ULA opcode width
//   REG_ADDR_W_DEF: default register-file address width
//   WAIT_CNT_W    : width of the EXEC wait down-counter
//   WAIT_MAX      : largest WAIT_CYCLES value the counter can hold
// ---------------------------------------------------------------------------
package ula_seq_pkg;

  localparam int OP_W_DEF       = 3;
  localparam int REG_ADDR_W_DEF = 2;
  localparam int WAIT_CNT_W     = 4;
  localparam int WAIT_MAX       = (1 << WAIT_CNT_W) - 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    EXEC  = 3'd3,
    GRAB  = 3'd4,
    DRIVE = 3'd5,
    WRITE = 3'd6
  } state_e;

endpackage

// File: rtl/ula_sequencer.sv
// ---------------------------------------------------------------------------
// ula_sequencer
// Multi-cycle control FSM that runs one ULA instruction on the processinho
// datapath: read operand A (and B unless unary), execute, capture the ULA
// result, drive it out, and write it back to the register file.
//
// Ports:
//   clock, reset       : rising-edge clock; synchronous active-low reset
//   start              : command valid, sampled only while ready=1
//   unary              : single-operand op, RD_B step skipped
//   opcode/src_a/src_b/dst : command fields, captured on acceptance
//   ready              : high in IDLE
//   done               : one-cycle pulse in the write-back cycle
//   reg_rd_addr, reg_out_en    : register-file read select / bus drive
//   a_grab, b_grab             : operand latch captures
//   ula_op                     : opcode to the ULA (RD_A..DRIVE, else 0)
//   ula_grab, ula_store_bus    : ULA result latch capture / drive
//   reg_wr_addr, reg_wr_en     : register-file write-back
//
// Optional feature (macro ULA_SEQ_FLAGS_EN):
//   ula_carry, ula_result in; flag_c, flag_z out. Flags are captured in
//   GRAB and held otherwise.
// ---------------------------------------------------------------------------
module ula_sequencer
  import ula_seq_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
`ifdef ULA_SEQ_FLAGS_EN
  input  logic                  ula_carry,
  input  logic [DATA_W-1:0]     ula_result,
  output logic                  flag_c,
  output logic                  flag_z,
`endif
  input  logic                  start,
  input  logic                  unary,
  input  logic [OP_W-1:0]       opcode,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  input  logic [REG_ADDR_W-1:0] dst,
  output logic                  ready,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] reg_rd_addr,
  output logic                  reg_out_en,
  output logic                  a_grab,
  output logic                  b_grab,
  output logic [OP_W-1:0]       ula_op,
  output logic                  ula_grab,
  output logic                  ula_store_bus,
  output logic [REG_ADDR_W-1:0] reg_wr_addr,
  output logic                  reg_wr_en
);

  // Elaboration-time parameter checks.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("ula_sequencer: WAIT_CYCLES must be in 0..15");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("ula_sequencer: DATA_W must be at least 1");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  typedef struct packed {
    logic                  unary;
    logic [OP_W-1:0]       opcode;
    logic [REG_ADDR_W-1:0] src_a;
    logic [REG_ADDR_W-1:0] src_b;
    logic [REG_ADDR_W-1:0] dst;
  } cmd_t;

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

`ifdef ULA_SEQ_FLAGS_EN
  logic flag_c_q, flag_c_d;
  logic flag_z_q, flag_z_d;
`endif

  // NOTE: reset is sampled on the clock edge only (synchronous), so it is not
  // in the sensitivity list; state uses non-blocking assignments so every
  // flop sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      wait_cnt_q <= '0;
`ifdef ULA_SEQ_FLAGS_EN
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wait_cnt_q <= wait_cnt_d;
`ifdef ULA_SEQ_FLAGS_EN
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
`endif
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a hold default before the case so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Command fields are frozen here until the next return to IDLE.
          cmd_d = '{unary: unary, opcode: opcode, src_a: src_a,
                    src_b: src_b, dst: dst};
          state_d = RD_A;
        end
      end
      RD_A: begin
        if (cmd_q.unary) begin
          state_d    = EXEC;
          wait_cnt_d = WAIT_LOAD;
        end else begin
          state_d = RD_B;
        end
      end
      RD_B: begin
        state_d    = EXEC;
        wait_cnt_d = WAIT_LOAD;
      end
      EXEC: begin
        // One base cycle plus WAIT_CYCLES extra, counted down to zero.
        if (wait_cnt_q == '0) begin
          state_d = GRAB;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end
      GRAB:    state_d = DRIVE;
      DRIVE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode from the registered state only.
  always_comb begin
    ready         = 1'b0;
    done          = 1'b0;
    reg_rd_addr   = '0;
    reg_out_en    = 1'b0;
    a_grab        = 1'b0;
    b_grab        = 1'b0;
    ula_op        = '0;
    ula_grab      = 1'b0;
    ula_store_bus = 1'b0;
    reg_wr_addr   = '0;
    reg_wr_en     = 1'b0;
    unique case (state_q)
      IDLE: ready = 1'b1;
      RD_A: begin
        reg_rd_addr = cmd_q.src_a;
        reg_out_en  = 1'b1;
        a_grab      = 1'b1;
        ula_op      = cmd_q.opcode;
      end
      RD_B: begin
        reg_rd_addr = cmd_q.src_b;
        reg_out_en  = 1'b1;
        b_grab      = 1'b1;
        ula_op      = cmd_q.opcode;
      end
      EXEC: ula_op = cmd_q.opcode;
      GRAB: begin
        ula_grab = 1'b1;
        ula_op   = cmd_q.opcode;
      end
      DRIVE: begin
        ula_store_bus = 1'b1;
        ula_op        = cmd_q.opcode;
      end
      WRITE: begin
        reg_wr_addr = cmd_q.dst;
        reg_wr_en   = 1'b1;
        done        = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ULA_SEQ_FLAGS_EN
  // Flags follow the ULA result that is being latched in GRAB.
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    if (state_q == GRAB) begin
      flag_c_d = ula_carry;
      flag_z_d = (ula_result == '0);
    end
  end

  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
`endif

endmodule

// File: tb/tb_ula_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ula_sequencer
// Drives two sequencers (WAIT_CYCLES = 0 and 2) with the same command stream
// and compares every output, every cycle, against a reference built from the
// instruction's step list: RD_A, RD_B (binary only), EXEC x (1+WAIT), GRAB,
// DRIVE, WRITE. Each accepted command appends its per-cycle expected outputs
// to a queue; an empty queue means the sequencer is idle and ready.
// Define ULA_SEQ_FLAGS_EN to also exercise the flag outputs.
// ---------------------------------------------------------------------------
module tb_ula_sequencer;

  localparam int N_DUT = 2;
  localparam int WAIT0 = 0;
  localparam int WAIT1 = 2;

  logic clock;
  logic reset;
  logic start, unary;
  logic [2:0] opcode;
  logic [1:0] src_a, src_b, dst;
  logic       ula_carry;
  logic [7:0] ula_result;

  logic       ready         [N_DUT];
  logic       done          [N_DUT];
  logic [1:0] reg_rd_addr   [N_DUT];
  logic       reg_out_en    [N_DUT];
  logic       a_grab        [N_DUT];
  logic       b_grab        [N_DUT];
  logic [2:0] ula_op        [N_DUT];
  logic       ula_grab      [N_DUT];
  logic       ula_store_bus [N_DUT];
  logic [1:0] reg_wr_addr   [N_DUT];
  logic       reg_wr_en     [N_DUT];
  logic       flag_c        [N_DUT];
  logic       flag_z        [N_DUT];

`ifndef ULA_SEQ_FLAGS_EN
  initial begin
    flag_c = '{default: 1'b0};
    flag_z = '{default: 1'b0};
  end
`endif

  ula_sequencer #(.DATA_W(8), .REG_ADDR_W(2), .OP_W(3), .WAIT_CYCLES(WAIT0)) u_dut0 (
    .clock(clock), .reset(reset),
`ifdef ULA_SEQ_FLAGS_EN
    .ula_carry(ula_carry), .ula_result(ula_result),
    .flag_c(flag_c[0]), .flag_z(flag_z[0]),
`endif
    .start(start), .unary(unary), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .ready(ready[0]), .done(done[0]),
    .reg_rd_addr(reg_rd_addr[0]), .reg_out_en(reg_out_en[0]),
    .a_grab(a_grab[0]), .b_grab(b_grab[0]), .ula_op(ula_op[0]),
    .ula_grab(ula_grab[0]), .ula_store_bus(ula_store_bus[0]),
    .reg_wr_addr(reg_wr_addr[0]), .reg_wr_en(reg_wr_en[0])
  );

  ula_sequencer #(.DATA_W(8), .REG_ADDR_W(2), .OP_W(3), .WAIT_CYCLES(WAIT1)) u_dut1 (
    .clock(clock), .reset(reset),
`ifdef ULA_SEQ_FLAGS_EN
    .ula_carry(ula_carry), .ula_result(ula_result),
    .flag_c(flag_c[1]), .flag_z(flag_z[1]),
`endif
    .start(start), .unary(unary), .opcode(opcode),
    .src_a(src_a), .src_b(src_b), .dst(dst),
    .ready(ready[1]), .done(done[1]),
    .reg_rd_addr(reg_rd_addr[1]), .reg_out_en(reg_out_en[1]),
    .a_grab(a_grab[1]), .b_grab(b_grab[1]), .ula_op(ula_op[1]),
    .ula_grab(ula_grab[1]), .ula_store_bus(ula_store_bus[1]),
    .reg_wr_addr(reg_wr_addr[1]), .reg_wr_en(reg_wr_en[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int wb_seen  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output vector layout:
  // {ready, done, rd_addr[1:0], out_en, a_grab, b_grab, ula_op[2:0],
  //  ula_grab, store_bus, wr_addr[1:0], wr_en}
  function automatic logic [15:0] mk(logic rdy, logic dn, logic [1:0] ra,
      logic oe, logic ag, logic bg, logic [2:0] op, logic ug, logic sb,
      logic [1:0] wa, logic we);
    return {rdy, dn, ra, oe, ag, bg, op, ug, sb, wa, we};
  endfunction

  function automatic logic [15:0] obs(int i);
    return {ready[i], done[i], reg_rd_addr[i], reg_out_en[i], a_grab[i],
            b_grab[i], ula_op[i], ula_grab[i], ula_store_bus[i],
            reg_wr_addr[i], reg_wr_en[i]};
  endfunction

  // Reference model: per-DUT queue of expected output vectors; bit 16 marks
  // the cycle in which the result (and flags) are captured.
  logic [16:0] mq [N_DUT][$];
  logic        exp_fc [N_DUT];
  logic        exp_fz [N_DUT];
  int          waits  [N_DUT];

  task automatic schedule(int i, logic un, logic [2:0] op, logic [1:0] a,
                          logic [1:0] b, logic [1:0] d);
    mq[i].push_back({1'b0, mk(0, 0, a, 1, 1, 0, op, 0, 0, 2'd0, 0)});
    if (!un) mq[i].push_back({1'b0, mk(0, 0, b, 1, 0, 1, op, 0, 0, 2'd0, 0)});
    for (int k = 0; k <= waits[i]; k++)
      mq[i].push_back({1'b0, mk(0, 0, 2'd0, 0, 0, 0, op, 0, 0, 2'd0, 0)});
    mq[i].push_back({1'b1, mk(0, 0, 2'd0, 0, 0, 0, op, 1, 0, 2'd0, 0)});
    mq[i].push_back({1'b0, mk(0, 0, 2'd0, 0, 0, 0, op, 0, 1, 2'd0, 0)});
    mq[i].push_back({1'b0, mk(0, 1, 2'd0, 0, 0, 0, 3'd0, 0, 0, d, 1)});
  endtask

  // One clock cycle: at the falling edge compare outputs, then apply the
  // inputs for the next rising edge and advance the model across that edge.
  task automatic step(input logic rst, input logic st, input logic un,
                      input logic [2:0] op, input logic [1:0] a,
                      input logic [1:0] b, input logic [1:0] d,
                      input logic cy, input logic [7:0] res);
    logic [15:0] exp_v;
    @(negedge clock);
    cyc++;
    for (int i = 0; i < N_DUT; i++) begin
      exp_v = (mq[i].size() != 0) ? mq[i][0][15:0]
                                  : mk(1, 0, 2'd0, 0, 0, 0, 3'd0, 0, 0, 2'd0, 0);
      check($sformatf("dut%0d outputs cyc%0d", i, cyc), 32'(obs(i)), 32'(exp_v));
      check($sformatf("dut%0d bus exclusive cyc%0d", i, cyc),
            {30'd0, reg_out_en[i] & reg_wr_en[i], a_grab[i] & b_grab[i]}, 32'd0);
`ifdef ULA_SEQ_FLAGS_EN
      check($sformatf("dut%0d flags cyc%0d", i, cyc),
            {30'd0, flag_c[i], flag_z[i]}, {30'd0, exp_fc[i], exp_fz[i]});
`endif
    end
    if (reg_wr_en[0] || done[0]) wb_seen++;
    reset = rst; start = st; unary = un; opcode = op;
    src_a = a; src_b = b; dst = d; ula_carry = cy; ula_result = res;
    for (int i = 0; i < N_DUT; i++) begin
      if (!rst) begin
        mq[i].delete();
        exp_fc[i] = 1'b0;
        exp_fz[i] = 1'b0;
      end else if (mq[i].size() == 0) begin
        if (st) schedule(i, un, op, a, b, d);
      end else begin
        if (mq[i][0][16]) begin
          exp_fc[i] = cy;
          exp_fz[i] = (res == 8'd0);
        end
        void'(mq[i].pop_front());
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFF);
  endtask

  initial begin
    waits[0] = WAIT0;
    waits[1] = WAIT1;
    exp_fc   = '{default: 1'b0};
    exp_fz   = '{default: 1'b0};
    reset = 1'b0; start = 1'b0; unary = 1'b0; opcode = '0;
    src_a = '0; src_b = '0; dst = '0; ula_carry = 1'b0; ula_result = 8'hFF;

    // Reset for two cycles; reset wins over start.
    step(0, 1, 0, 3'd5, 2'd1, 2'd1, 2'd1, 1'b0, 8'hFF);
    step(0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFF);
    idle(2);

    // Binary op: opcode 010, A=1, B=2, D=3.
    step(1, 1, 0, 3'b010, 2'd1, 2'd2, 2'd3, 1'b0, 8'hFF);
    idle(11);

    // Unary op.
    step(1, 1, 1, 3'b110, 2'd2, 2'd0, 2'd2, 1'b0, 8'hFF);
    idle(10);

    // Start held high with inputs changing mid-command.
    for (int k = 0; k < 24; k++)
      step(1, 1, k[0], 3'(k + 1), 2'(k), 2'(k + 1), 2'(k + 2), 1'b0, 8'hFF);
    idle(10);

    // Reset during GRAB of the WAIT=0 instance: no write-back may follow.
    wb_seen = 0;
    step(1, 1, 0, 3'b011, 2'd0, 2'd1, 2'd2, 1'b0, 8'hFF);
    idle(3);
    step(0, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'hFF);
    idle(8);
    check("no write-back after mid-op reset", 32'(wb_seen), 32'd0);

`ifdef ULA_SEQ_FLAGS_EN
    // Zero result with carry, then non-zero result without carry.
    step(1, 1, 0, 3'b001, 2'd1, 2'd2, 2'd3, 1'b1, 8'h00);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00);
    check("flag_c after zero result", 32'(flag_c[0]), 32'd1);
    check("flag_z after zero result", 32'(flag_z[0]), 32'd1);
    step(1, 1, 1, 3'b100, 2'd0, 2'd0, 2'd1, 1'b0, 8'h05);
    for (int k = 0; k < 10; k++) step(1, 0, 0, 3'd0, 2'd0, 2'd0, 2'd0, 1'b0, 8'h05);
    check("flag_c after 0x05 result", 32'(flag_c[0]), 32'd0);
    check("flag_z after 0x05 result", 32'(flag_z[0]), 32'd0);
`endif

    // Random traffic with occasional resets.
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
           1'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
           2'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
